// File: rtl/nth_root_iter_if.sv
// nth_root_iter_if
//   Operand/result handshake bundle for the k-th root engine.
//   master : operand producer / result consumer (drives in_*, out_ready)
//   slave  : the engine (drives in_ready, out_*)
//   in_valid/in_ready   operand handshake, in_data_1 = radicand X, in_data_2 = order k
//   out_valid/out_ready result handshake, out_data = root (FRAC_W fraction bits), out_err = bad order
interface nth_root_iter_if #(
    parameter int IN_W   = 10,
    parameter int FRAC_W = 10,
    parameter int ORD_W  = 3
);
    localparam int OUT_W = IN_W + FRAC_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data_1;
    logic [ORD_W-1:0] in_data_2;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_data_1, in_data_2, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data_1, in_data_2, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/nth_root_iter.sv
// nth_root_iter
//   Multi-cycle k-th root: out_data = floor(X^(1/k) * 2^FRAC_W), one result bit
//   per iteration MSB first, trial powers built by repeated multiplication.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : nth_root_iter_if.slave (operand and result ready/valid handshakes)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for an operand
//   LOAD  | acc <= trial, start of the power for the current bit
//   POW   | acc <= acc*trial until trial^k is formed (k-1 cycles)
//   CMP   | compare trial^k with target, keep or drop the bit
//   DONE  | out_valid=1, result held until out_ready
module nth_root_iter #(
    parameter int IN_W    = 10,
    parameter int FRAC_W  = 10,
    parameter int ORD_W   = 3,
    parameter int MAX_ORD = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    nth_root_iter_if.slave bus
);
    localparam int OUT_W = IN_W + FRAC_W;
    localparam int T_W   = IN_W + MAX_ORD * FRAC_W;
    localparam int P_W   = OUT_W * MAX_ORD;
    localparam int BIT_W = $clog2(OUT_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_POW,
        S_CMP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ORD_W-1:0]   k_q, k_d;
    logic [T_W-1:0]     target_q, target_d;
    logic [OUT_W-1:0]   res_q, res_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [P_W-1:0]     acc_q, acc_d;
    logic [ORD_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [OUT_W-1:0]   trial;
    logic [P_W-1:0]     trial_ext;
    logic [P_W-1:0]     target_ext;
    logic               ord_bad;

    assign trial      = res_q | (OUT_W'(1) << bit_q);
    assign trial_ext  = P_W'(trial);
    assign target_ext = P_W'(target_q);
    assign ord_bad    = (bus.in_data_2 == '0) || (bus.in_data_2 > ORD_W'(MAX_ORD));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            target_q <= '0;
            res_q    <= '0;
            bit_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            target_q <= target_d;
            res_q    <= res_d;
            bit_q    <= bit_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        target_d = target_q;
        res_d    = res_q;
        bit_d    = bit_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    k_d      = bus.in_data_2;
                    // illegal orders may shift X entirely out; result is forced to 0 anyway
                    target_d = T_W'(bus.in_data_1) << (bus.in_data_2 * FRAC_W);
                    res_d    = '0;
                    bit_d    = BIT_W'(OUT_W - 1);
                    err_d    = ord_bad;
                    if (ord_bad || bus.in_data_1 == '0) state_d = S_DONE;
                    else                                 state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                acc_d   = trial_ext;
                cnt_d   = ORD_W'(1);
                state_d = (k_q == ORD_W'(1)) ? S_CMP : S_POW;
            end
            S_POW: begin
                // trial < 2^OUT_W, so trial^MAX_ORD fits in P_W without wrapping
                acc_d = acc_q * trial_ext;
                cnt_d = cnt_q + ORD_W'(1);
                if (cnt_d == k_q) state_d = S_CMP;
            end
            S_CMP: begin
                if (acc_q == target_ext) begin
                    res_d   = trial;
                    state_d = S_DONE;
                end else begin
                    if (acc_q < target_ext) res_d = trial;
                    if (bit_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d   = bit_q - BIT_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // res is cleared on every accept, so it already reads 0 on the error and X==0 paths
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.out_data  = res_q;
        bus.out_err   = err_q;
    end
endmodule

// File: tb/tb_nth_root_iter.sv
module tb_nth_root_iter;
    localparam int IN_W    = 10;
    localparam int FRAC_W  = 10;
    localparam int ORD_W   = 3;
    localparam int MAX_ORD = 5;
    localparam int OUT_W   = IN_W + FRAC_W;
    localparam int BUDGET  = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    nth_root_iter_if #(.IN_W(IN_W), .FRAC_W(FRAC_W), .ORD_W(ORD_W)) bus ();

    nth_root_iter #(
        .IN_W(IN_W), .FRAC_W(FRAC_W), .ORD_W(ORD_W), .MAX_ORD(MAX_ORD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pw(input logic [127:0] b, input int k);
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < k; i++) p = p * b;
        return p;
    endfunction

    // reference: real-valued estimate refined with exact integer powers
    task automatic ref_model(input int x, input int k,
                             output logic [63:0] r_data, output logic r_err, output int r_lat);
        logic [127:0] tgt, r;
        real          est;
        int           lsb, n;
        r_data = 0; r_err = 1'b0; r_lat = 1;
        if (k == 0 || k > MAX_ORD) begin
            r_err = 1'b1;
            return;
        end
        if (x == 0) return;
        tgt = 128'(x) << (k * FRAC_W);
        est = (real'(x) ** (1.0 / real'(k))) * 1024.0;
        r   = 128'($rtoi($floor(est)));
        if (r > 128'((1 << OUT_W) - 1)) r = 128'((1 << OUT_W) - 1);
        while (r < 128'((1 << OUT_W) - 1) && pw(r + 128'd1, k) <= tgt) r = r + 128'd1;
        while (pw(r, k) > tgt) r = r - 128'd1;
        r_data = 64'(r);
        n = OUT_W;
        if (pw(r, k) == tgt) begin
            lsb = 0;
            while (r[lsb] == 1'b0) lsb++;
            n = OUT_W - lsb;
        end
        r_lat = 1 + n * (k + 1);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.in_ready && t < BUDGET) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    endtask

    // called at accept edge + 1; follows the result to completion and consumes it
    task automatic wait_result(input string tag, input int x, input int k);
        logic [63:0] e_data;
        logic        e_err;
        int          e_lat, lat;
        ref_model(x, k, e_data, e_err, e_lat);
        lat = 1;
        while (!bus.out_valid && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_lat"},   64'(lat),           64'(e_lat));
        chk({tag, "_data"},  64'(bus.out_data),  e_data);
        chk({tag, "_err"},   64'(bus.out_err),   64'(e_err));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input int x, input int k);
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.in_data_1 = IN_W'(x);
        bus.in_data_2 = ORD_W'(k);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
        wait_result(tag, x, k);
    endtask

    initial begin
        logic [63:0] e_data;
        logic        e_err;
        int          e_lat;

        bus.in_valid  = 1'b1;
        bus.in_data_1 = IN_W'(8);
        bus.in_data_2 = ORD_W'(3);
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_err",   64'(bus.out_err),   64'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_consume", 64'(bus.in_ready), 64'd1);

        run_op("x8k3",    8,    3);
        run_op("x2k2",    2,    2);
        run_op("x1023k1", 1023, 1);
        run_op("x5k0",    5,    0);
        run_op("x5k7",    5,    7);
        run_op("x0k5",    0,    5);

        // backpressure with a pending operand
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.in_data_1 = IN_W'(1000);
        bus.in_data_2 = ORD_W'(5);
        @(posedge clk); #1;
        bus.in_data_1 = IN_W'(16);
        bus.in_data_2 = ORD_W'(4);
        ref_model(1000, 5, e_data, e_err, e_lat);
        begin
            int lat = 1;
            while (!bus.out_valid && lat < BUDGET) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("bp_lat", 64'(lat), 64'(e_lat));
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_data",  64'(bus.out_data),  e_data);
            chk("bp_hold_ready", 64'(bus.in_ready),  64'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_bubble_ready", 64'(bus.in_ready),  64'd1);
        chk("bp_bubble_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_pending_taken", 64'(bus.in_ready), 64'd0);
        wait_result("bp_x16k4", 16, 4);

        // reset while the k=4 power loop is running
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.in_data_1 = IN_W'(500);
        bus.in_data_2 = ORD_W'(4);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_out_data",  64'(bus.out_data),  64'd0);
        chk("mid_rst_out_err",   64'(bus.out_err),   64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_result", 64'(bus.out_valid), 64'd0);
        run_op("post_rst_x16k4", 16, 4);

        for (int i = 0; i < 24; i++) begin
            int x, k;
            x = $urandom_range(0, (1 << IN_W) - 1);
            k = $urandom_range(0, (1 << ORD_W) - 1);
            if (i % 6 == 0) x = $urandom_range(1, 40);
            run_op("rand", x, k);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
